pixel_ram_arbiter: RTL

//   Shares one read-only pixel RAM (60x60 image, 3-bit pixels) between two scanners:

---
 rtl/pixel_ram_arbiter_if.sv | 35 +++
 rtl/pixel_ram_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/pixel_ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pixel_ram_arbiter_if                                            |
// | Purpose  : Requester handshakes and RAM port of the pixel RAM arbiter.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface pixel_ram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 3
) ();
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic              busy;

  modport slave (
    input  req0, addr0, req1, addr1, ram_q,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, ram_addr, busy
  );

  modport master (
    output req0, addr0, req1, addr1, ram_q,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, ram_addr, busy
  );
endinterface
`default_nettype wire

// File: rtl/pixel_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pixel_ram_arbiter                                               |
// | Purpose  : Round-robin sharing of one read-only pixel RAM by two scanners. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pixel_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 3,
  parameter int RD_LAT = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  pixel_ram_arbiter_if.slave bus
);
  localparam int c_TAIL = RD_LAT - 1;

  logic              r_ptr;
  logic [ADDR_W-1:0] r_lastAddr;
  logic [RD_LAT-1:0] r_tagValid;
  logic [RD_LAT-1:0] r_tagOwner;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_any;
  logic              w_win;
  logic [ADDR_W-1:0] w_winAddr;

  // Pointer only matters under contention; a lone requester always wins.
  always_comb begin
    w_any     = bus.req0 | bus.req1;
    w_win     = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
    w_winAddr = w_win ? bus.addr1 : bus.addr0;
  end

  assign bus.gnt0     = bus.req0 & ~w_win;
  assign bus.gnt1     = bus.req1 & w_win;
  assign bus.ram_addr = w_any ? w_winAddr : r_lastAddr;
  assign bus.busy     = |r_tagValid;
  assign bus.rvalid0  = r_rvalid0;
  assign bus.rvalid1  = r_rvalid1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= 1'b0;
      r_lastAddr <= '0;
      r_tagValid <= '0;
      r_tagOwner <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      if (w_any) begin
        r_ptr      <= ~w_win;
        r_lastAddr <= w_winAddr;
      end
      r_tagValid[0] <= w_any;
      r_tagOwner[0] <= w_win;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagOwner[i] <= r_tagOwner[i-1];
      end
      // Tail entry lines up with ram_q for the read it tracks.
      r_rvalid0 <= r_tagValid[c_TAIL] & ~r_tagOwner[c_TAIL];
      r_rvalid1 <= r_tagValid[c_TAIL] & r_tagOwner[c_TAIL];
      if (r_tagValid[c_TAIL] && !r_tagOwner[c_TAIL]) begin
        r_rdata0 <= bus.ram_q;
      end
      if (r_tagValid[c_TAIL] && r_tagOwner[c_TAIL]) begin
        r_rdata1 <= bus.ram_q;
      end
    end
  end
endmodule
`default_nettype wire
